// File: rtl/i_mem_pkg.sv
// Shared constants, in-flight stage type and a count-width helper for the
// instruction prefetcher and its buffer.
package i_mem_pkg;

  localparam logic [7:0] I_MEM_FILL_BYTE  = 8'h00;
  localparam int         BRAM_LATENCY_MAX = 4;

  typedef struct packed {
    logic vld;
    logic zf;
  } fl_stage_t;

  // A count register must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i_mem_pf_fifo.sv
// Byte circular buffer: push at tail, pop at head, flush empties it in one edge.
// Head byte is combinational; the caller guarantees it never pushes while full.
module i_mem_pf_fifo
  import i_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_push_dat,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [7:0]    o_head_dat,
  output logic [CW-1:0] o_cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !i_flush && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_head_dat = (r_cnt != '0) ? r_mem[r_rd_ptr] : I_MEM_FILL_BYTE;

endmodule

// File: rtl/i_mem_prefetch.sv
// Sequential instruction prefetcher between a byte fetch port and a BRAM of latency L.
// Hits ack in the request cycle; a jump acks L+2 cycles later; issue stops when credit runs out.
module i_mem_prefetch
  import i_mem_pkg::*;
#(
  parameter int I_ADDR_WIDTH = 16,
  parameter int I_MEM_LENGTH = 1024,
  parameter int BRAM_LATENCY = 1,
  parameter int PF_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic [I_ADDR_WIDTH-1:0] i_addr,
  output logic                    i_ack,
  output logic [7:0]              i_rdata,
  output logic                    m_en,
  output logic [I_ADDR_WIDTH-1:0] m_addr,
  input  logic [7:0]              m_rdata
);

  localparam int CW      = cnt_width(PF_DEPTH);
  localparam int ASPACE  = 1 << I_ADDR_WIDTH;
  localparam int MEM_TOP = (I_MEM_LENGTH > ASPACE) ? ASPACE : I_MEM_LENGTH;
  localparam logic [I_ADDR_WIDTH:0] MEM_LIMIT = (I_ADDR_WIDTH+1)'(MEM_TOP);
  localparam logic [CW:0]           CREDITS   = (CW+1)'(PF_DEPTH);

  logic [I_ADDR_WIDTH-1:0] r_ha;
  logic [I_ADDR_WIDTH-1:0] r_nf;
  logic                    r_nf_wrap;
  fl_stage_t               r_fl [BRAM_LATENCY];

  logic [CW-1:0] w_cnt;
  logic [7:0]    w_head;
  logic [CW:0]   w_inflight;
  logic [CW:0]   w_used;
  logic          w_hit;
  logic          w_miss;
  logic          w_credit;
  logic          w_issue;
  logic          w_in_range;
  logic          w_push;
  logic [7:0]    w_push_dat;
  fl_stage_t     w_fl_out;

  assign w_hit  = i_req && (w_cnt != '0) && (i_addr == r_ha);
  assign w_miss = i_req && (i_addr != r_ha);

  // Credit is taken from registered state only, so a pop frees space one cycle later.
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < BRAM_LATENCY; k++)
      w_inflight = w_inflight + {{CW{1'b0}}, r_fl[k].vld};
  end

  assign w_used     = {1'b0, w_cnt} + w_inflight;
  assign w_credit   = (w_used < CREDITS);
  assign w_issue    = !rst && !w_miss && w_credit;
  assign w_in_range = !r_nf_wrap && ({1'b0, r_nf} < MEM_LIMIT);

  assign w_fl_out   = r_fl[BRAM_LATENCY-1];
  assign w_push     = w_fl_out.vld && !w_miss;
  assign w_push_dat = w_fl_out.zf ? I_MEM_FILL_BYTE : m_rdata;

  // Once the fetch address rolls over the top, it keeps zero-filling until a jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ha      <= '0;
      r_nf      <= '0;
      r_nf_wrap <= 1'b0;
      for (int k = 0; k < BRAM_LATENCY; k++) r_fl[k] <= '0;
    end else if (w_miss) begin
      r_ha      <= i_addr;
      r_nf      <= i_addr;
      r_nf_wrap <= 1'b0;
      for (int k = 0; k < BRAM_LATENCY; k++) r_fl[k] <= '0;
    end else begin
      if (w_hit) r_ha <= r_ha + 1'b1;
      if (w_issue) begin
        r_nf <= r_nf + 1'b1;
        if (&r_nf) r_nf_wrap <= 1'b1;
      end
      r_fl[0] <= '{vld: w_issue, zf: !w_in_range};
      for (int k = 1; k < BRAM_LATENCY; k++) r_fl[k] <= r_fl[k-1];
    end
  end

  i_mem_pf_fifo #(
    .DEPTH (PF_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_hit),
    .i_flush    (w_miss),
    .o_head_dat (w_head),
    .o_cnt      (w_cnt)
  );

  assign m_en    = w_issue && w_in_range;
  assign m_addr  = r_nf;
  assign i_ack   = w_hit && !rst;
  assign i_rdata = rst ? I_MEM_FILL_BYTE : w_head;

endmodule

// File: tb/tb_i_mem_prefetch.sv
// Bench for i_mem_prefetch: BRAM model holding mem[a] = a[7:0] ^ 0x5A, per-scenario tasks,
// and a fetch-level reference (byte values and ack latency in cycles).
module tb_i_mem_prefetch;

  localparam int AW    = 16;
  localparam int LEN   = 1024;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [7:0]    i_rdata;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_rdata;

  int total = 0;
  int bad   = 0;
  int oob   = 0;
  logic [AW-1:0] issued [$];
  logic [7:0]    bram_pipe [LAT];

  always #5 clk = ~clk;

  i_mem_prefetch #(
    .I_ADDR_WIDTH (AW),
    .I_MEM_LENGTH (LEN),
    .BRAM_LATENCY (LAT),
    .PF_DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .m_en    (m_en),
    .m_addr  (m_addr),
    .m_rdata (m_rdata)
  );

  function automatic logic [7:0] ref_byte(input logic [AW-1:0] a);
    if (int'(a) < LEN) return a[7:0] ^ 8'h5A;
    return 8'h00;
  endfunction

  // BRAM model: garbage when not enabled so an unrequested read shows up as wrong data.
  always @(posedge clk) begin
    bram_pipe[0] <= m_en ? ref_byte(m_addr) : 8'hEE;
    for (int k = 1; k < LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign m_rdata = bram_pipe[LAT-1];

  always @(negedge clk) begin
    if (rst === 1'b0 && m_en === 1'b1) begin
      issued.push_back(m_addr);
      if (int'(m_addr) >= LEN) oob++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the ack cycle. lat = -1 on timeout.
  task automatic fetch(input logic [AW-1:0] a, output logic [7:0] d, output int lat);
    bit got = 1'b0;
    i_req = 1'b1; i_addr = a; d = 8'h00; lat = -1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (i_ack === 1'b1) begin got = 1'b1; d = i_rdata; lat = c; end
      @(posedge clk); #1;
    end
    i_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    i_req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 1'b1; i_addr = '0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", i_ack); end
    total++; if (i_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", i_rdata); end
    total++; if (m_en !== 1'b0) begin bad++; $display("FAIL rst_m_en got=%b want=0", m_en); end
    total++; if (m_addr !== 16'h0) begin bad++; $display("FAIL rst_m_addr got=%h want=0000", m_addr); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (m_en !== 1'b1 || m_addr !== 16'h0) begin bad++; $display("FAIL c0_issue got en=%b addr=%h want en=1 addr=0000", m_en, m_addr); end
    total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL c0_ack got=%b want=0", i_ack); end
    @(negedge clk);
    total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL c1_ack got=%b want=0", i_ack); end
    @(negedge clk);
    total++; if (i_ack !== 1'b1 || i_rdata !== 8'h5A) begin bad++; $display("FAIL c2_ack got ack=%b d=%h want ack=1 d=5a", i_ack, i_rdata); end
    @(posedge clk); #1 i_req = 1'b0;
  endtask

  task automatic test_streaming();
    logic [7:0] d; int lat;
    apply_reset();
    for (int a = 0; a < 16; a++) begin
      fetch(AW'(a), d, lat);
      total++; if (d !== ref_byte(AW'(a))) begin bad++; $display("FAIL stream_data a=%0d got=%h want=%h", a, d, ref_byte(AW'(a))); end
      total++; if (lat != ((a == 0) ? LAT + 1 : 0)) begin bad++; $display("FAIL stream_lat a=%0d got=%0d want=%0d", a, lat, (a == 0) ? LAT + 1 : 0); end
    end
  endtask

  task automatic test_jump();
    logic [7:0] d; int lat;
    apply_reset();
    for (int a = 0; a <= 4; a++) fetch(AW'(a), d, lat);
    issued.delete();
    fetch(16'h0020, d, lat);
    total++; if (d !== 8'h7A || lat != LAT + 2) begin bad++; $display("FAIL jump_ack got d=%h lat=%0d want d=7a lat=%0d", d, lat, LAT + 2); end
    total++;
    if (issued.size() < 3) begin bad++; $display("FAIL jump_issue_count got=%0d want>=3", issued.size()); end
    else if (issued[0] !== 16'h0020 || issued[1] !== 16'h0021 || issued[2] !== 16'h0022) begin
      bad++; $display("FAIL jump_issue_seq got=%h,%h,%h want=0020,0021,0022", issued[0], issued[1], issued[2]);
    end
    for (int a = 'h21; a <= 'h22; a++) begin
      fetch(AW'(a), d, lat);
      total++; if (d !== ref_byte(AW'(a)) || lat != 0) begin bad++; $display("FAIL jump_follow a=%h got d=%h lat=%0d want d=%h lat=0", a, d, lat, ref_byte(AW'(a))); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] d; int lat;
    idle(9);
    @(negedge clk);
    total++; if (m_en !== 1'b0) begin bad++; $display("FAIL stall_m_en got=%b want=0", m_en); end
    total++; if (dut.w_cnt !== 3'd4) begin bad++; $display("FAIL stall_cnt got=%0d want=4", dut.w_cnt); end
    @(posedge clk); #1;
    for (int a = 'h23; a <= 'h27; a++) begin
      fetch(AW'(a), d, lat);
      total++; if (d !== ref_byte(AW'(a))) begin bad++; $display("FAIL stall_data a=%h got=%h want=%h", a, d, ref_byte(AW'(a))); end
      if (a < 'h27) begin
        total++; if (lat != 0) begin bad++; $display("FAIL stall_lat a=%h got=%0d want=0", a, lat); end
      end
    end
  endtask

  task automatic test_end_of_mem();
    logic [7:0] d; int lat;
    oob = 0;
    fetch(16'h03FE, d, lat);
    total++; if (d !== 8'hA4 || lat != LAT + 2) begin bad++; $display("FAIL eom_3fe got d=%h lat=%0d want d=a4 lat=%0d", d, lat, LAT + 2); end
    fetch(16'h03FF, d, lat);
    total++; if (d !== 8'hA5 || lat != 0) begin bad++; $display("FAIL eom_3ff got d=%h lat=%0d want d=a5 lat=0", d, lat); end
    fetch(16'h0400, d, lat);
    total++; if (d !== 8'h00 || lat != 0) begin bad++; $display("FAIL eom_400 got d=%h lat=%0d want d=00 lat=0", d, lat); end
    fetch(16'h0401, d, lat);
    total++; if (d !== 8'h00 || lat != 0) begin bad++; $display("FAIL eom_401 got d=%h lat=%0d want d=00 lat=0", d, lat); end
    idle(8);
    total++; if (oob != 0) begin bad++; $display("FAIL eom_oob got=%0d want=0", oob); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; int lat;
    fetch(16'h01F0, d, lat);
    total++; if (d !== 8'hAA) begin bad++; $display("FAIL mid_pre got=%h want=aa", d); end
    idle(2);
    rst = 1'b1; i_req = 1'b1; i_addr = 16'h01F1;
    @(negedge clk);
    total++; if (i_ack !== 1'b0 || i_rdata !== 8'h00) begin bad++; $display("FAIL mid_rst got ack=%b d=%h want ack=0 d=00", i_ack, i_rdata); end
    @(posedge clk); #1 rst = 1'b0;
    fetch(16'h0000, d, lat);
    total++; if (d !== 8'h5A || lat != LAT + 1) begin bad++; $display("FAIL mid_first got d=%h lat=%0d want d=5a lat=%0d", d, lat, LAT + 1); end
    fetch(16'h0001, d, lat);
    total++; if (d !== 8'h5B || lat != 0) begin bad++; $display("FAIL mid_second got d=%h lat=%0d want d=5b lat=0", d, lat); end
  endtask

  // Reference: a request for the address after the last ack hits at once; anything else
  // costs L+2 cycles; the byte is always mem[a] or 0x00 beyond the program.
  task automatic test_random();
    logic [7:0] d; int lat; int exp_lat;
    logic [AW-1:0] a, next_seq;
    apply_reset();
    fetch(16'h0000, d, lat);
    total++; if (d !== 8'h5A || lat != LAT + 1) begin bad++; $display("FAIL rnd_first got d=%h lat=%0d want d=5a lat=%0d", d, lat, LAT + 1); end
    next_seq = 16'h0001;
    for (int i = 0; i < 60; i++) begin
      idle(int'($urandom_range(0, 3)));
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 1279)) : next_seq;
      exp_lat = (a == next_seq) ? 0 : LAT + 2;
      fetch(a, d, lat);
      total++; if (d !== ref_byte(a) || lat != exp_lat) begin bad++; $display("FAIL rnd i=%0d a=%h got d=%h lat=%0d want d=%h lat=%0d", i, a, d, lat, ref_byte(a), exp_lat); end
      next_seq = a + 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    test_reset();
    test_streaming();
    test_jump();
    test_stall();
    test_end_of_mem();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
